// File: rtl/tree_pkg.sv
// rtl/tree_pkg.sv - shared tree node record layout and loader FSM encoding
// Shared by tree_loader and the tree evaluator.
// Node record: {parent[31:22], action[21:19], strat[18], reward[17:8], weight[7:0]}
package tree_pkg;

    localparam int NODE_SIZE = 32;
    localparam int W_ADDR    = 10;
    localparam int W_ACTION  = 3;
    localparam int W_STRAT   = 1;
    localparam int W_REWARD  = 10;
    localparam int W_WEIGHT  = 8;

    localparam int PARENT_LSB = 22;
    localparam int ACTION_LSB = 19;
    localparam int STRAT_LSB  = 18;
    localparam int REWARD_LSB = 8;
    localparam int WEIGHT_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        CONF,
        PAR,
        ACT,
        REW,
        WGT,
        FIN
    } tree_state_t;

endpackage

// File: rtl/tree_loader_fifo.sv
// rtl/tree_loader_fifo.sv - synchronous node-record FIFO with registered full/empty
// Ports: clk, rst (async, active-high, flushes), push/wdata, pop/rdata (head,
// valid while !empty), full, empty. DEPTH must be a power of 2.
module tree_loader_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      level;
    logic [AW:0]      level_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_comb begin
        level_n = level;
        if (do_push && !do_pop) begin
            level_n = level + 1'b1;
        end else if (!do_push && do_pop) begin
            level_n = level - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            level <= level_n;
            full  <= (level_n == FULL_LEVEL);
            empty <= (level_n == '0);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/tree_loader.sv
// rtl/tree_loader.sv - serialises tree config and node records into evaluator sideband writes
// Ports: cfg_valid/cfg_ready/cfg_count (tree size handshake), node_valid/
// node_ready/node_data (record stream), conf_nodes/conf_data, mem_par/mem_act/
// mem_rew/mem_weight with mem_addr/mem_data (field writes), busy, done, cfg_err.
// Optional TREE_LOADER_CKSUM_EN adds cksum[15:0] over accepted records.
module tree_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int W_ADDR     = tree_pkg::W_ADDR,
    parameter int NODE_SIZE  = tree_pkg::NODE_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [W_ADDR-1:0]    cfg_count,
    input  logic                 node_valid,
    output logic                 node_ready,
    input  logic [NODE_SIZE-1:0] node_data,
    output logic                 conf_nodes,
    output logic [W_ADDR-1:0]    conf_data,
    output logic                 mem_par,
    output logic                 mem_act,
    output logic                 mem_rew,
    output logic                 mem_weight,
    output logic [W_ADDR-1:0]    mem_addr,
    output logic [W_ADDR-1:0]    mem_data,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
`ifdef TREE_LOADER_CKSUM_EN
    ,
    output logic [15:0]          cksum
`endif
);

    import tree_pkg::*;

    tree_state_t          state;
    tree_state_t          state_n;
    logic [W_ADDR-1:0]    count;
    logic [W_ADDR-1:0]    widx;
    logic [W_ADDR-1:0]    accept_cnt;
    logic                 conf_sent;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 cfg_fire;
    logic                 last_node;
    logic [NODE_SIZE-1:0] head;

    logic                 conf_nodes_n;
    logic [W_ADDR-1:0]    conf_data_n;
    logic                 mem_par_n;
    logic                 mem_act_n;
    logic                 mem_rew_n;
    logic                 mem_weight_n;
    logic [W_ADDR-1:0]    mem_addr_n;
    logic [W_ADDR-1:0]    mem_data_n;
    logic                 done_n;
    logic                 cfg_err_n;

    assign cfg_ready  = (state == IDLE);
    // Built only from registered state, so a full FIFO blocks pushes even in its pop cycle.
    assign node_ready = (state != IDLE) && !fifo_full && (accept_cnt < count);
    assign push       = node_valid && node_ready;
    assign pop        = (state == WGT);
    assign cfg_fire   = cfg_valid && (state == IDLE) && (cfg_count >= W_ADDR'(2));
    assign last_node  = (widx == count - 1'b1);

    tree_loader_fifo #(
        .WIDTH (NODE_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (node_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_n      = state;
        conf_nodes_n = 1'b0;
        conf_data_n  = conf_data;
        mem_par_n    = 1'b0;
        mem_act_n    = 1'b0;
        mem_rew_n    = 1'b0;
        mem_weight_n = 1'b0;
        mem_addr_n   = mem_addr;
        mem_data_n   = '0;
        done_n       = 1'b0;
        cfg_err_n    = 1'b0;
        case (state)
            IDLE: begin
                cfg_err_n = cfg_valid && !cfg_fire;
                if (cfg_fire) begin
                    state_n = CONF;
                end
            end
            CONF: begin
                conf_nodes_n = !conf_sent;
                conf_data_n  = count;
                // A record landing this cycle lets PAR start without a bubble.
                if (!fifo_empty || push) begin
                    state_n = PAR;
                end
            end
            PAR: begin
                // Empty FIFO here is the hold sub-state: no strobe, wait for data.
                if (!fifo_empty) begin
                    mem_par_n  = 1'b1;
                    mem_addr_n = widx;
                    mem_data_n = head[PARENT_LSB +: W_ADDR];
                    state_n    = ACT;
                end
            end
            ACT: begin
                mem_act_n                        = 1'b1;
                mem_addr_n                       = widx;
                mem_data_n[W_ACTION-1:0]         = head[ACTION_LSB +: W_ACTION];
                mem_data_n[W_ACTION +: W_STRAT]  = head[STRAT_LSB +: W_STRAT];
                state_n                          = REW;
            end
            REW: begin
                mem_rew_n                 = 1'b1;
                mem_addr_n                = widx;
                mem_data_n[W_REWARD-1:0]  = head[REWARD_LSB +: W_REWARD];
                state_n                   = WGT;
            end
            WGT: begin
                mem_weight_n              = 1'b1;
                mem_addr_n                = widx;
                mem_data_n[W_WEIGHT-1:0]  = head[WEIGHT_LSB +: W_WEIGHT];
                state_n                   = last_node ? FIN : PAR;
            end
            FIN: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            widx       <= '0;
            accept_cnt <= '0;
            conf_sent  <= 1'b0;
            conf_nodes <= 1'b0;
            conf_data  <= '0;
            mem_par    <= 1'b0;
            mem_act    <= 1'b0;
            mem_rew    <= 1'b0;
            mem_weight <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state     <= state_n;
            conf_sent <= (state == CONF);
            if (cfg_fire) begin
                count      <= cfg_count;
                widx       <= '0;
                accept_cnt <= '0;
            end else begin
                if (push) begin
                    accept_cnt <= accept_cnt + 1'b1;
                end
                if (pop) begin
                    widx <= widx + 1'b1;
                end
            end
            conf_nodes <= conf_nodes_n;
            conf_data  <= conf_data_n;
            mem_par    <= mem_par_n;
            mem_act    <= mem_act_n;
            mem_rew    <= mem_rew_n;
            mem_weight <= mem_weight_n;
            mem_addr   <= mem_addr_n;
            mem_data   <= mem_data_n;
            busy       <= (state_n != IDLE);
            done       <= done_n;
            cfg_err    <= cfg_err_n;
        end
    end

`ifdef TREE_LOADER_CKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum <= '0;
        end else if (cfg_fire) begin
            cksum <= '0;
        end else if (push) begin
            cksum <= cksum + (node_data[31:16] ^ node_data[15:0]);
        end
    end
`endif

endmodule

// File: tb/tb_tree_loader.sv
// tb/tb_tree_loader.sv - self-checking bench for tree_loader with a record-level reference model
module tb_tree_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [9:0]  cfg_count;
    logic        node_valid;
    logic        node_ready;
    logic [31:0] node_data;
    logic        conf_nodes;
    logic [9:0]  conf_data;
    logic        mem_par;
    logic        mem_act;
    logic        mem_rew;
    logic        mem_weight;
    logic [9:0]  mem_addr;
    logic [9:0]  mem_data;
    logic        busy;
    logic        done;
    logic        cfg_err;
`ifdef TREE_LOADER_CKSUM_EN
    logic [15:0] cksum;
`endif

    always #5 clk = ~clk;

    tree_loader dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_count  (cfg_count),
        .node_valid (node_valid),
        .node_ready (node_ready),
        .node_data  (node_data),
        .conf_nodes (conf_nodes),
        .conf_data  (conf_data),
        .mem_par    (mem_par),
        .mem_act    (mem_act),
        .mem_rew    (mem_rew),
        .mem_weight (mem_weight),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
`ifdef TREE_LOADER_CKSUM_EN
        ,
        .cksum      (cksum)
`endif
    );

    typedef struct {
        int kind;
        int addr;
        int data;
        int hot;
        int cyc;
    } wr_t;

    wr_t         obs_q[$];
    wr_t         mon_w;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          conf_cnt = 0;
    int          conf_cyc = 0;
    int          conf_val = 0;
    int          total = 0;
    int          bad = 0;
    int          obs_base = 0;
    logic [31:0] rec[16];
    int          f_par[16];
    int          f_act[16];
    int          f_str[16];
    int          f_rew[16];
    int          f_wgt[16];
    int          push_cyc[16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_par || mem_act || mem_rew || mem_weight) begin
                mon_w.kind = mem_par ? 0 : mem_act ? 1 : mem_rew ? 2 : 3;
                mon_w.addr = int'(mem_addr);
                mon_w.data = int'(mem_data);
                mon_w.hot  = int'(mem_par) + int'(mem_act) + int'(mem_rew) + int'(mem_weight);
                mon_w.cyc  = cyc;
                obs_q.push_back(mon_w);
            end
            if (conf_nodes) begin
                conf_cnt = conf_cnt + 1;
                conf_cyc = cyc;
                conf_val = int'(conf_data);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic set_rec(input int i, input int par, input int act, input int str,
                           input int rew, input int wgt);
        f_par[i] = par;
        f_act[i] = act;
        f_str[i] = str;
        f_rew[i] = rew;
        f_wgt[i] = wgt;
        rec[i] = (32'(par) << 22) | (32'(act) << 19) | (32'(str) << 18)
               | (32'(rew & 1023) << 8) | 32'(wgt);
    endtask

    task automatic rand_rec(input int i);
        int r;
        r = int'($urandom_range(0, 1023)) - 512;
        set_rec(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 1)), r, int'($urandom_range(0, 255)));
    endtask

    function automatic int exp_field(input int i, input int k);
        case (k)
            0:       return f_par[i];
            1:       return f_str[i] * 8 + f_act[i];
            2:       return f_rew[i] & 1023;
            default: return f_wgt[i];
        endcase
    endfunction

    function automatic int exp_cksum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) begin
            s = (s + int'((rec[i] >> 16) ^ (rec[i] & 32'hFFFF))) % 65536;
        end
        return s;
    endfunction

    task automatic chk_writes(input string tag, input int n);
        int j;
        int o;
        chk({tag, ":nwr"}, obs_q.size() - obs_base, 4 * n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                j = obs_base + 4 * i + k;
                if (j < obs_q.size()) begin
                    o = (obs_q[j].hot << 24) | (obs_q[j].kind << 20) | (obs_q[j].addr << 10) | obs_q[j].data;
                    chk($sformatf("%s:wr%0d", tag, 4 * i + k), o,
                        (1 << 24) | (k << 20) | (i << 10) | exp_field(i, k));
                end
            end
        end
    endtask

    task automatic start_load(input int n, output int hs);
        cfg_valid = 1'b1;
        cfg_count = 10'(n);
        @(negedge clk);
        chk("cfg_ready_idle", int'(cfg_ready), 1);
        hs = cyc + 1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    // Host model: offers nsup records in order, optionally pausing before
    // record gap_idx until earlier nodes have drained, and optionally
    // asserting rst when the REW write of abort_addr is seen.
    task automatic feed(input int nsup, input int cnt, input int gap_idx, input int gap_len,
                        input int abort_addr, output int acc, output int stalled,
                        output int late, output int aborted, output int tmo);
        int  idx = 0;
        int  gap_left;
        int  base_done;
        bit  fire;
        bit  finished = 0;
        gap_left  = (gap_idx >= 0) ? -1 : 0;
        base_done = done_cnt;
        acc = 0; stalled = 0; late = 0; aborted = 0;
        for (int c = 0; c < 400 && !finished; c++) begin
            if (idx < nsup && !(idx == gap_idx && gap_left != 0)) begin
                node_valid = 1'b1;
                node_data  = rec[idx];
            end else begin
                node_valid = 1'b0;
            end
            @(negedge clk);
            if (abort_addr >= 0 && mem_rew && int'(mem_addr) == abort_addr) begin
                rst = 1'b1;
                #1;
                node_valid = 1'b0;
                aborted = 1;
                finished = 1;
            end else if (done_cnt != base_done) begin
                node_valid = 1'b0;
                finished = 1;
            end else begin
                fire = node_valid && node_ready;
                if (node_valid && !node_ready && acc < cnt) stalled = 1;
                if (acc >= cnt && node_ready) late = 1;
                if (idx == gap_idx && gap_left < 0 && (obs_q.size() - obs_base) >= 4 * gap_idx)
                    gap_left = gap_len;
                else if (idx == gap_idx && gap_left > 0)
                    gap_left--;
                @(posedge clk);
                #1;
                if (fire) begin
                    push_cyc[idx] = cyc;
                    idx++;
                    acc++;
                end
            end
        end
        tmo = finished ? 0 : 1;
    endtask

    initial begin
        int hs, acc, stalled, late, aborted, tmo, d0, c0, j;
        cfg_valid  = 1'b0;
        cfg_count  = '0;
        node_valid = 1'b0;
        node_data  = '0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_node_ready", int'(node_ready), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_strobes", int'({conf_nodes, mem_par, mem_act, mem_rew, mem_weight}), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_data", int'(mem_data), 0);
        chk("rst_conf_data", int'(conf_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load of 3 with a known record at address 1.
        obs_base = obs_q.size(); d0 = done_cnt; c0 = conf_cnt;
        rand_rec(0);
        set_rec(1, 0, 2, 1, -5, 64);
        rand_rec(2);
        start_load(3, hs);
        feed(3, 3, -1, 0, -1, acc, stalled, late, aborted, tmo);
        chk("t1_timeout", tmo, 0);
        chk("t1_accepted", acc, 3);
        chk("t1_conf_cnt", conf_cnt - c0, 1);
        chk("t1_conf_cyc", conf_cyc - hs, 1);
        chk("t1_conf_data", conf_val, 3);
        chk_writes("t1", 3);
        if (obs_q.size() > obs_base) chk("t1_first_wr_cyc", obs_q[obs_base].cyc - hs, 2);
        chk("t1_done_lat", done_cyc - hs, 14);
        chk("t1_done_cnt", done_cnt - d0, 1);
`ifdef TREE_LOADER_CKSUM_EN
        chk("t1_cksum", int'(cksum), exp_cksum(3));
`endif
        @(negedge clk);
        chk("t1_done_pulse", int'(done), 0);
        chk("t1_busy_after", int'(busy), 0);
        @(posedge clk);
        #1;

        // Rejected configs.
        for (int t = 0; t < 2; t++) begin
            obs_base = obs_q.size(); c0 = conf_cnt;
            cfg_valid = 1'b1;
            cfg_count = 10'(t);
            @(posedge clk);
            #1;
            cfg_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("t2_cfg_err_%0d", t), int'(cfg_err), 1);
            chk($sformatf("t2_cfg_ready_%0d", t), int'(cfg_ready), 1);
            chk($sformatf("t2_busy_%0d", t), int'(busy), 0);
            @(negedge clk);
            chk($sformatf("t2_err_pulse_%0d", t), int'(cfg_err), 0);
            chk($sformatf("t2_no_writes_%0d", t), obs_q.size() - obs_base + conf_cnt - c0, 0);
            @(posedge clk);
            #1;
        end

        // Host offers 6 records for a tree of 4.
        obs_base = obs_q.size();
        for (int i = 0; i < 6; i++) rand_rec(i);
        start_load(4, hs);
        feed(6, 4, -1, 0, -1, acc, stalled, late, aborted, tmo);
        chk("t3_timeout", tmo, 0);
        chk("t3_accepted", acc, 4);
        chk("t3_ready_after_count", late, 0);
        chk_writes("t3", 4);
`ifdef TREE_LOADER_CKSUM_EN
        chk("t3_cksum", int'(cksum), exp_cksum(4));
`endif
        @(posedge clk);
        #1;

        // Tree of 8 against a 4-deep FIFO: host must be back-pressured.
        obs_base = obs_q.size();
        for (int i = 0; i < 8; i++) rand_rec(i);
        start_load(8, hs);
        feed(8, 8, -1, 0, -1, acc, stalled, late, aborted, tmo);
        chk("t4_timeout", tmo, 0);
        chk("t4_accepted", acc, 8);
        chk("t4_backpressure", stalled, 1);
        chk_writes("t4", 8);
        chk("t4_done_lat", done_cyc - hs, 4 * 8 + 2);
        @(posedge clk);
        #1;

        // Input gap after node 2 drains.
        obs_base = obs_q.size();
        for (int i = 0; i < 5; i++) rand_rec(i);
        start_load(5, hs);
        feed(5, 5, 3, 5, -1, acc, stalled, late, aborted, tmo);
        chk("t5_timeout", tmo, 0);
        chk_writes("t5", 5);
        j = obs_base + 12;
        if (j < obs_q.size()) begin
            chk("t5_par_after_push", obs_q[j].cyc - push_cyc[3], 1);
            chk("t5_gap_seen", int'(obs_q[j].cyc - obs_q[j - 1].cyc > 1), 1);
        end
        @(posedge clk);
        #1;

        // Reset during REW of the fifth node of ten, then a fresh load of 2.
        obs_base = obs_q.size(); d0 = done_cnt;
        for (int i = 0; i < 10; i++) rand_rec(i);
        start_load(10, hs);
        feed(10, 10, -1, 0, 4, acc, stalled, late, aborted, tmo);
        chk("t6_aborted", aborted, 1);
        chk("t6_rst_strobes", int'({conf_nodes, mem_par, mem_act, mem_rew, mem_weight}), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_node_ready", int'(node_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt - d0, 0);
        obs_base = obs_q.size();
        rand_rec(0);
        rand_rec(1);
        start_load(2, hs);
        feed(2, 2, -1, 0, -1, acc, stalled, late, aborted, tmo);
        chk("t6_timeout", tmo, 0);
        chk_writes("t6", 2);
        chk("t6_done_lat", done_cyc - hs, 4 * 2 + 2);
`ifdef TREE_LOADER_CKSUM_EN
        chk("t6_cksum", int'(cksum), exp_cksum(2));
`endif
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
